ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: wait states per non-idle transfer, 0..7.
REQ-003 SHALL have port HCLK, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port s_addr_req, input, 1: address phase valid from the interconnect.
REQ-006 SHALL have port s_addr_ack, output, 1: address phase accepted this cycle.
REQ-007 SHALL have port s_data_ack, output, 1: data phase completes this cycle (HREADYOUT).
REQ-008 SHALL have ports s_hsel (1), s_htrans (2), s_hwrite (1), s_hmastlock (1), s_hsize (3), s_hburst (3), s_hprot (4), s_haddr (32), all inputs: AHB address-phase controls.
REQ-009 SHALL have port s_hwdata, input, 32: write data, sampled in the data phase.
REQ-010 SHALL have port s_hrdata, output, 32: read data.
REQ-011 SHALL have port s_hresp, output, 1: 0 = OKAY, 1 = ERROR.

Function
REQ-012 SHALL treat a transfer as active when s_addr_req & s_hsel & s_htrans[1] & s_addr_ack are all 1 at a rising edge.
REQ-013 SHALL accept IDLE and BUSY transfers with an OKAY response, no wait states and no memory access.
REQ-014 SHALL ignore s_hmastlock, s_hburst and s_hprot.
REQ-015 SHALL implement these states:
- IDLE: no data phase pending.
- WAIT: wait counter running.
- LAST: completing cycle.
- ERR1, ERR2: error response cycles.
REQ-016 SHALL make transitions on an active transfer as follows: to WAIT if WAIT_CYCLES > 0, otherwise to LAST; the counter loads WAIT_CYCLES-1.
REQ-017 SHALL hold WAIT while the counter is nonzero, decrementing it each cycle, then go to LAST.
REQ-018 SHALL leave LAST for IDLE, WAIT or LAST according to whether a new transfer is accepted in that same cycle.
REQ-019 SHALL drive s_data_ack = 1 in IDLE, LAST and ERR2, and 0 in WAIT and ERR1.
REQ-020 SHALL drive s_addr_ack = s_data_ack, so that a new address is accepted only in the cycle the previous data phase completes (pipelined overlap).
REQ-021 SHALL give a data phase a length of WAIT_CYCLES+1 cycles; WAIT_CYCLES = 0 SHALL sustain one transfer per cycle.
REQ-022 SHALL apply a write in the LAST cycle, committing s_hwdata at the closing edge to byte lanes selected by s_hsize/s_haddr[1:0], little-endian:
- byte: lane = haddr[1:0].
- halfword: lanes per haddr[1].
- word: all lanes.
REQ-023 SHALL drive the full addressed word on s_hrdata in the read LAST cycle, and 0 in every other cycle.
REQ-024 SHALL return post-write data when a read data phase directly follows a write to the same word, byte-merged through a bypass path.
REQ-025 SHALL form the word index from s_haddr[log2(DEPTH_WORDS)+1:2].

Reset
REQ-026 SHALL, while HRESETn = 0, force the state to IDLE, the counter to 0, s_addr_ack = 1, s_data_ack = 1, s_hresp = 0 and s_hrdata = 0.
REQ-027 SHALL discard a reset asserted mid-transfer: no pending write is committed.
REQ-028 SHALL NOT reset memory contents; they remain undefined after reset.

Configuration
REQ-029 SHALL, with AHB_SRAM_ERR_RESP_EN defined, treat the following as errors: s_hsize > 2, a misaligned halfword or word, or s_haddr >= DEPTH_WORDS*4.
REQ-030 SHALL, for an error, skip wait states, go to ERR1 (s_data_ack = 0, s_hresp = 1) and then ERR2 (s_data_ack = 1, s_hresp = 1).
REQ-031 SHALL NOT modify memory on an error.
REQ-032 SHALL NOT accept a new address in ERR1.
REQ-033 SHALL, without AHB_SRAM_ERR_RESP_EN, hold s_hresp at 0 and never enter ERR1/ERR2.
REQ-034 SHALL, without AHB_SRAM_ERR_RESP_EN:
- ignore address bits above the index, so the address wraps modulo DEPTH_WORDS;
- use the low bits per hsize;
- treat hsize > 2 as a word access.

Verification
REQ-035 SHALL cover: WAIT_CYCLES = 0, word write 0x12345678 @0x10, then read @0x10 next cycle -> s_data_ack high every cycle and read returns 0x12345678 via bypass.
REQ-036 SHALL cover: WAIT_CYCLES = 3, read @0x0 -> s_data_ack low 3 cycles then high 1 cycle; s_addr_ack low during the wait cycles.
REQ-037 SHALL cover: memory word 0xAABBCCDD, byte write 0x11 @0x2 -> later read returns 0xAA11CCDD.
REQ-038 SHALL cover: with the macro, word write @0x2 -> ERR1 then ERR2 with s_hresp = 1, and the word is unchanged.
REQ-039 SHALL cover: without the macro, DEPTH_WORDS = 16, write 0xCAFEF00D @0x40 -> read @0x0 returns 0xCAFEF00D.
REQ-040 SHALL cover: HRESETn low in the second WAIT cycle of a write -> outputs return to reset values and the target word is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB SRAM slave with programmable wait states and a write-to-read bypass
// Optional error responses for bad size/alignment/range: define AHB_SRAM_ERR_RESP_EN
module ahb_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        s_addr_req,
    output logic        s_addr_ack,
    output logic        s_data_ack,
    input  logic        s_hsel,
    input  logic [1:0]  s_htrans,
    input  logic        s_hwrite,
    input  logic        s_hmastlock,
    input  logic [2:0]  s_hsize,
    input  logic [2:0]  s_hburst,
    input  logic [3:0]  s_hprot,
    input  logic [31:0] s_haddr,
    input  logic [31:0] s_hwdata,
    output logic [31:0] s_hrdata,
    output logic        s_hresp
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [AW-1:0] idx_q;
    logic          wr_q;
    logic [3:0]    lanes_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          active;
    logic          addr_err;
    logic          commit;
    logic [3:0]    lanes;
    logic [AW-1:0] idx;
    logic [31:0]   fwd_word;
    logic          unused;

    assign unused = ^{s_hmastlock, s_hburst, s_hprot, s_htrans[0], s_haddr[31:AW+2]};

    assign active = s_addr_req & s_hsel & s_htrans[1] & s_addr_ack;
    assign idx    = s_haddr[AW+1:2];
    assign commit = (state == ST_LAST) && wr_q;

    // Little-endian lane select; any size above halfword is a full word.
    always_comb begin
        lanes = 4'b1111;
        if (s_hsize == 3'd0) begin
            lanes = 4'b0001 << s_haddr[1:0];
        end else if (s_hsize == 3'd1) begin
            lanes = s_haddr[1] ? 4'b1100 : 4'b0011;
        end
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    assign addr_err = (s_hsize > 3'd2)
                   || (s_hsize == 3'd1 && s_haddr[0])
                   || (s_hsize == 3'd2 && s_haddr[1:0] != 2'b00)
                   || (s_haddr[31:AW+2] != '0);
`else
    assign addr_err = 1'b0;
`endif

    // The array is read at address acceptance; a write committing on that same
    // edge is merged in here so the following read sees post-write data.
    always_comb begin
        fwd_word = mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && idx_q == idx && lanes_q[b]) begin
                fwd_word[b*8 +: 8] = s_hwdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= s_hwdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            lanes_q <= 4'b0000;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (active) begin
                idx_q   <= idx;
                wr_q    <= s_hwrite;
                lanes_q <= lanes;
                rdata_q <= fwd_word;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_nxt = cnt - 3'd1;
                end else begin
                    state_nxt = ST_LAST;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (!active) begin
                    state_nxt = ST_IDLE;
                end else if (addr_err) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_CYCLES > 0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end else begin
                    state_nxt = ST_LAST;
                end
            end
        endcase
    end

    always_comb begin
        s_data_ack = 1'b1;
        s_hresp    = 1'b0;
        s_hrdata   = 32'd0;
        case (state)
            ST_WAIT: s_data_ack = 1'b0;
            ST_ERR1: begin
                s_data_ack = 1'b0;
                s_hresp    = 1'b1;
            end
            ST_ERR2: s_hresp = 1'b1;
            ST_LAST: if (!wr_q) s_hrdata = rdata_q;
            default: ;
        endcase
        s_addr_ack = s_data_ack;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave
// Instance 0: WAIT_CYCLES=0, instance 1: WAIT_CYCLES=3, both DEPTH_WORDS=16
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    localparam int DEPTH = 16;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_n, addr_req, addr_ack, data_ack, hsel, hwrite, hmastlock, hresp;
    logic [1:0][1:0]   htrans;
    logic [1:0][2:0]   hsize, hburst;
    logic [1:0][3:0]   hprot;
    logic [1:0][31:0]  haddr, hwdata, hrdata;

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .HCLK(clk), .HRESETn(rst_n[0]), .s_addr_req(addr_req[0]), .s_addr_ack(addr_ack[0]),
        .s_data_ack(data_ack[0]), .s_hsel(hsel[0]), .s_htrans(htrans[0]), .s_hwrite(hwrite[0]),
        .s_hmastlock(hmastlock[0]), .s_hsize(hsize[0]), .s_hburst(hburst[0]), .s_hprot(hprot[0]),
        .s_haddr(haddr[0]), .s_hwdata(hwdata[0]), .s_hrdata(hrdata[0]), .s_hresp(hresp[0]));

    ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .HCLK(clk), .HRESETn(rst_n[1]), .s_addr_req(addr_req[1]), .s_addr_ack(addr_ack[1]),
        .s_data_ack(data_ack[1]), .s_hsel(hsel[1]), .s_htrans(htrans[1]), .s_hwrite(hwrite[1]),
        .s_hmastlock(hmastlock[1]), .s_hsize(hsize[1]), .s_hburst(hburst[1]), .s_hprot(hprot[1]),
        .s_haddr(haddr[1]), .s_hwdata(hwdata[1]), .s_hrdata(hrdata[1]), .s_hresp(hresp[1]));

    typedef struct {
        int          dut;
        logic [1:0]  trans;
        logic        sel;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } xfer_t;

    xfer_t       tab[$];
    xfer_t       txq[$];
    logic [31:0] model [2][DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int wait_cycles(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic xfer_t mk(input int d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                                 input logic err);
        xfer_t x;
        x.dut = d; x.trans = tr; x.sel = 1'b1; x.wr = wr; x.size = sz;
        x.addr = a; x.wdata = wd; x.exp_rdata = er; x.exp_err = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory: word index wraps modulo depth; lanes follow the size rule.
    task automatic model_write(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int w = int'((a >> 2) % DEPTH);
        for (int b = 0; b < 4; b++) begin
            bit en = (sz == 0) ? (b == int'(a[1:0])) : (sz == 1) ? ((b / 2) == int'(a[1])) : 1'b1;
            if (en) model[d][w][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    task automatic drive_idle(input int d);
        addr_req[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = T_IDLE; hwrite[d] = 1'b0;
        hsize[d] = 3'd0; haddr[d] = 32'd0;
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        addr_req[d] = 1'b1; hsel[d] = x.sel; htrans[d] = x.trans; hwrite[d] = x.wr;
        hsize[d] = x.size; haddr[d] = x.addr;
        hmastlock[d] = 1'($urandom); hburst[d] = 3'($urandom); hprot[d] = 4'($urandom);
    endtask

    // Pipelined master: next address is offered while the previous data phase runs.
    task automatic run_list(input int d);
        xfer_t dp, x;
        bit    has_dp = 0;
        bit    take;
        int    waits = 0;
        int    guard = 0;
        while ((txq.size() != 0 || has_dp) && guard < 3000) begin
            guard++;
            if (txq.size() != 0) drive_addr(d, txq[0]);
            else drive_idle(d);
            hwdata[d] = (has_dp && dp.wr) ? dp.wdata : $urandom;
            @(negedge clk);
            chk("addr_ack_eq_data_ack", 32'(addr_ack[d]), 32'(data_ack[d]));
            if (has_dp) begin
                if (data_ack[d]) begin
                    chk("wait_states", 32'(waits), 32'(dp.exp_err ? 1 : wait_cycles(d)));
                    chk("rdata", hrdata[d], dp.wr ? 32'd0 : dp.exp_rdata);
                    chk("hresp_done", 32'(hresp[d]), 32'(dp.exp_err));
                    has_dp = 0;
                end else begin
                    waits++;
                    chk("rdata_in_wait", hrdata[d], 32'd0);
                    chk("hresp_in_wait", 32'(hresp[d]), 32'(dp.exp_err));
                    if (waits > 8) begin
                        n_cmp++; n_bad++;
                        $display("FAIL data_phase_timeout: got %0d low cycles, expected <= 8", waits);
                        has_dp = 0;
                    end
                end
            end else begin
                chk("idle_data_ack", 32'(data_ack[d]), 32'd1);
                chk("idle_rdata", hrdata[d], 32'd0);
                chk("idle_hresp", 32'(hresp[d]), 32'd0);
            end
            take = (txq.size() != 0) && addr_ack[d];
            @(posedge clk); #1;
            if (take) begin
                x = txq.pop_front();
                if (x.sel && x.trans[1]) begin
                    dp = x; has_dp = 1; waits = 0;
                end
            end
        end
        if (guard >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL list_timeout: got %0d cycles, expected < 3000", guard);
        end
        txq.delete();
        drive_idle(d);
    endtask

    task automatic gen_random(input int d, input int n);
        xfer_t x;
        for (int w = 0; w < DEPTH; w++) begin
            x = mk(d, T_NSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom, 32'd0, 1'b0);
            model_write(d, x.size, x.addr, x.wdata);
            txq.push_back(x);
        end
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 7);
            x = mk(d, (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 5) ? T_NSEQ : T_SEQ,
                   1'($urandom), 3'($urandom_range(0, 2)), 32'd0, $urandom, 32'd0, 1'b0);
            x.sel = ($urandom_range(0, 9) != 0);
`ifdef AHB_SRAM_ERR_RESP_EN
            x.addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            if (x.size == 3'd1) x.addr[0] = 1'b0;
            if (x.size == 3'd2) x.addr[1:0] = 2'b00;
`else
            x.addr = $urandom;
            if ($urandom_range(0, 3) == 0) x.size = 3'($urandom_range(3, 7));
`endif
            if (x.sel && x.trans[1]) begin
                if (x.wr) model_write(d, x.size, x.addr, x.wdata);
                else x.exp_rdata = model[d][int'((x.addr >> 2) % DEPTH)];
            end
            txq.push_back(x);
        end
    endtask

    initial begin
        xfer_t x;
        logic [31:0] keep;
        rst_n = 2'b00; hwdata = '0; hmastlock = '0; hburst = '0; hprot = '0;
        drive_idle(0); drive_idle(1);

        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h10, 32'h12345678, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h10, 0, 32'h12345678, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h08, 32'hAABBCCDD, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 0, 32'h0A, 32'hEE11EEEE, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h08, 0, 32'hAA11CCDD, 0));
        tab.push_back(mk(0, T_IDLE, 1, 2, 32'h08, 0, 0, 0));
        tab.push_back(mk(0, T_BUSY, 1, 2, 32'h08, 0, 0, 0));
        x = mk(0, T_NSEQ, 1, 2, 32'h10, 32'h0, 0, 0); x.sel = 1'b0;
        tab.push_back(x);
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h08, 0, 32'hAA11CCDD, 0));
        tab.push_back(mk(0, T_SEQ,  0, 2, 32'h10, 0, 32'h12345678, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h04, 32'h01020304, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 1, 32'h06, 32'hBEEF5555, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 0, 32'h04, 32'h777777A5, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h04, 0, 32'hBEEF03A5, 0));
`ifdef AHB_SRAM_ERR_RESP_EN
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h00, 32'h0BADF00D, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h02, 32'h12345678, 0, 1));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h00, 0, 32'h0BADF00D, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 1, 32'h05, 32'hFFFFFFFF, 0, 1));
        tab.push_back(mk(0, T_NSEQ, 1, 3, 32'h00, 32'hFFFFFFFF, 0, 1));
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h40, 32'hFFFFFFFF, 0, 1));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h40, 0, 0, 1));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h00, 0, 32'h0BADF00D, 0));
`else
        tab.push_back(mk(0, T_NSEQ, 1, 2, 32'h40, 32'hCAFEF00D, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h00, 0, 32'hCAFEF00D, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 3, 32'h14, 32'h55AA55AA, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h14, 0, 32'h55AA55AA, 0));
        tab.push_back(mk(0, T_NSEQ, 1, 1, 32'h17, 32'h98764321, 0, 0));
        tab.push_back(mk(0, T_NSEQ, 0, 2, 32'h14, 0, 32'h987655AA, 0));
`endif
        tab.push_back(mk(1, T_NSEQ, 1, 2, 32'h00, 32'h76543210, 0, 0));
        tab.push_back(mk(1, T_NSEQ, 0, 2, 32'h00, 0, 32'h76543210, 0));
        tab.push_back(mk(1, T_NSEQ, 1, 2, 32'h08, 32'h11112222, 0, 0));
        tab.push_back(mk(1, T_NSEQ, 1, 0, 32'h09, 32'h0000EE00, 0, 0));
        tab.push_back(mk(1, T_NSEQ, 0, 2, 32'h08, 0, 32'h1111EE22, 0));

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_addr_ack", 32'(addr_ack[d]), 32'd1);
            chk("reset_data_ack", 32'(data_ack[d]), 32'd1);
            chk("reset_hresp", 32'(hresp[d]), 32'd0);
            chk("reset_hrdata", hrdata[d], 32'd0);
        end
        rst_n = 2'b11;
        @(posedge clk); #1;

        for (int i = 0; i < tab.size(); i++) begin
            txq.push_back(tab[i]);
            if (i == tab.size() - 1 || tab[i + 1].dut != tab[i].dut) run_list(tab[i].dut);
        end

        for (int d = 0; d < 2; d++) begin
            gen_random(d, 150);
            run_list(d);
        end

        // Reset in the second wait cycle of a write must drop the write.
        keep = model[1][2];
        drive_addr(1, mk(1, T_NSEQ, 1, 2, 32'h08, 32'h99999999, 0, 0));
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'h99999999;
        @(negedge clk);
        chk("wait1_data_ack", 32'(data_ack[1]), 32'd0);
        @(posedge clk); #1;
        chk("wait2_data_ack", 32'(data_ack[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("midreset_addr_ack", 32'(addr_ack[1]), 32'd1);
        chk("midreset_data_ack", 32'(data_ack[1]), 32'd1);
        chk("midreset_hresp", 32'(hresp[1]), 32'd0);
        chk("midreset_hrdata", hrdata[1], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        txq.push_back(mk(1, T_NSEQ, 0, 2, 32'h08, 0, keep, 0));
        run_list(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
